// File: rtl/rv32i_pkg.sv
// Shared RV32I core definitions: register-file geometry, the x0 constant and
// the state encoding of the register-file access sequencer.
package rv32i_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

    typedef enum logic [2:0] {
        IDLE,
        RD1,
        RD2,
        CAP2,
        OUT
    } rf_seq_state_t;

endpackage

// File: rtl/regfile_access_sequencer.sv
// Arbitrates the single-port register file between writeback and operand
// reads, hiding the one-cycle read latency and forcing x0 to read as zero.
module regfile_access_sequencer
    import rv32i_pkg::*;
#(
    parameter int ADDR_WIDTH = REG_ADDR_W,
    parameter int DATA_WIDTH = XLEN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_rs1,
    input  logic [ADDR_WIDTH-1:0] req_rs2,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic [ADDR_WIDTH-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  opnd_valid,
    input  logic                  opnd_ready,
    output logic [DATA_WIDTH-1:0] opnd_rs1_data,
    output logic [DATA_WIDTH-1:0] opnd_rs2_data,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    input  logic [DATA_WIDTH-1:0] rf_rdata
);

    localparam logic [ADDR_WIDTH-1:0] X0 = ADDR_WIDTH'(REG_X0);

    rf_seq_state_t state;
    rf_seq_state_t next_state;

    logic [ADDR_WIDTH-1:0] rs1_q;
    logic [ADDR_WIDTH-1:0] rs2_q;

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        wb_ready   = 1'b0;
        rf_we      = 1'b0;
        rf_addr    = '0;
        rf_wdata   = '0;

        case (state)
            IDLE: begin
                // Writeback wins so a later read always observes the new value
                if (wb_valid) begin
                    wb_ready = 1'b1;
                    rf_we    = (wb_rd != X0);
                    rf_addr  = wb_rd;
                    rf_wdata = wb_data;
                end else begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        next_state = RD1;
                    end
                end
            end
            RD1: begin
                rf_addr    = rs1_q;
                next_state = RD2;
            end
            RD2: begin
                rf_addr    = rs2_q;
                next_state = CAP2;
            end
            CAP2: begin
                next_state = OUT;
            end
            OUT: begin
                if (opnd_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        // Nothing leaves the block while reset is held, including a pending write
        if (!rst) begin
            req_ready = 1'b0;
            wb_ready  = 1'b0;
            rf_we     = 1'b0;
            rf_addr   = '0;
            rf_wdata  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            rs1_q         <= '0;
            rs2_q         <= '0;
            opnd_valid    <= 1'b0;
            opnd_rs1_data <= '0;
            opnd_rs2_data <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && req_valid && req_ready) begin
                rs1_q <= req_rs1;
                rs2_q <= req_rs2;
            end
            // The file returns data one cycle after the address: rs1 lands in RD2, rs2 in CAP2
            if (state == RD2) begin
                opnd_rs1_data <= (rs1_q == X0) ? '0 : rf_rdata;
            end
            if (state == CAP2) begin
                opnd_rs2_data <= (rs2_q == X0) ? '0 : rf_rdata;
                opnd_valid    <= 1'b1;
            end
            if (state == OUT && opnd_ready) begin
                opnd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_access_sequencer.sv
// Randomised self-checking bench for regfile_access_sequencer with a
// behavioural register-file model and an architectural register shadow.
module tb_regfile_access_sequencer;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_rs1;
    logic [AW-1:0] req_rs2;
    logic          wb_valid;
    logic          wb_ready;
    logic [AW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic          opnd_valid;
    logic          opnd_ready;
    logic [DW-1:0] opnd_rs1_data;
    logic [DW-1:0] opnd_rs2_data;
    logic          rf_we;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_wdata;
    logic [DW-1:0] rf_rdata;

    // Register-file model, its power-up contents, and the expected architectural state
    logic [DW-1:0] mem      [32];
    logic [DW-1:0] seed_val [32];
    logic [DW-1:0] ref_regs [32];
    logic          seed_mem;
    int            x0_we_count = 0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_access_sequencer #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_rs1      (req_rs1),
        .req_rs2      (req_rs2),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .opnd_valid   (opnd_valid),
        .opnd_ready   (opnd_ready),
        .opnd_rs1_data(opnd_rs1_data),
        .opnd_rs2_data(opnd_rs2_data),
        .rf_we        (rf_we),
        .rf_addr      (rf_addr),
        .rf_wdata     (rf_wdata),
        .rf_rdata     (rf_rdata)
    );

    always @(posedge clk) begin
        if (seed_mem) begin
            for (int i = 0; i < 32; i++) mem[i] <= seed_val[i];
        end else if (rf_we) begin
            mem[rf_addr] <= rf_wdata;
            if (rf_addr == 0) x0_we_count <= x0_we_count + 1;
        end
        rf_rdata <= mem[rf_addr];
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [DW-1:0] expectedRead(input logic [AW-1:0] r);
        return (r == 0) ? '0 : ref_regs[r];
    endfunction

    task automatic applyWrite(input logic [AW-1:0] rd, input logic [DW-1:0] d);
        int wait_cnt;
        @(negedge clk);
        wb_valid = 1'b1;
        wb_rd    = rd;
        wb_data  = d;
        #1;
        wait_cnt = 0;
        while (!wb_ready && wait_cnt < 20) begin
            @(negedge clk);
            #1;
            wait_cnt++;
        end
        checkOutput("wb_ready", wb_ready, 1);
        checkOutput("rf_we", rf_we, rd != 0);
        checkOutput("rf_addr_wr", rf_addr, rd);
        checkOutput("rf_wdata", rf_wdata, d);
        @(posedge clk);
        if (rd != 0) ref_regs[rd] = d;
        #1;
        wb_valid = 1'b0;
    endtask

    task automatic applyRead(input logic [AW-1:0] a, input logic [AW-1:0] b, input int stall);
        int            wait_cnt;
        int            lat;
        logic [DW-1:0] exp1;
        logic [DW-1:0] exp2;
        @(negedge clk);
        req_valid = 1'b1;
        req_rs1   = a;
        req_rs2   = b;
        #1;
        wait_cnt = 0;
        while (!req_ready && wait_cnt < 20) begin
            @(negedge clk);
            #1;
            wait_cnt++;
        end
        checkOutput("req_ready", req_ready, 1);
        exp1 = expectedRead(a);
        exp2 = expectedRead(b);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        while (!opnd_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("latency", lat, 3);
        checkOutput("rs1_data", opnd_rs1_data, exp1);
        checkOutput("rs2_data", opnd_rs2_data, exp2);
        for (int s = 0; s < stall; s++) begin
            wb_valid  = 1'b1;
            wb_rd     = AW'($urandom_range(31, 1));
            wb_data   = $urandom;
            req_valid = 1'b1;
            #1;
            checkOutput("stall_wb_ready", wb_ready, 0);
            checkOutput("stall_req_ready", req_ready, 0);
            checkOutput("stall_rf_we", rf_we, 0);
            checkOutput("stall_valid", opnd_valid, 1);
            checkOutput("stall_rs1", opnd_rs1_data, exp1);
            checkOutput("stall_rs2", opnd_rs2_data, exp2);
            @(negedge clk);
        end
        wb_valid   = 1'b0;
        req_valid  = 1'b0;
        opnd_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        opnd_ready = 1'b0;
        checkOutput("valid_drop", opnd_valid, 0);
    endtask

    // Reset mid-read: the request in flight must vanish without producing operands
    task automatic applyResetInRd2();
        logic saw_valid;
        @(negedge clk);
        req_valid = 1'b1;
        req_rs1   = 5'd5;
        req_rs2   = 5'd7;
        #1;
        checkOutput("rst_req_ready", req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_mid_valid", opnd_valid, 0);
        checkOutput("rst_mid_rf_addr", rf_addr, 0);
        checkOutput("rst_mid_rs1", opnd_rs1_data, 0);
        @(negedge clk);
        rst = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (opnd_valid) saw_valid = 1'b1;
        end
        checkOutput("rst_no_operands", saw_valid, 0);
        #1;
        checkOutput("rst_back_idle", req_ready, 1);
        applyRead(5'd5, 5'd7, 0);
    endtask

    task automatic applyStimulus();
        int x0_before;
        applyWrite(5'd5, 32'hDEADBEEF);
        applyRead(5'd5, 5'd0, 0);

        x0_before = x0_we_count;
        applyWrite(5'd0, 32'h12345678);
        applyRead(5'd0, 5'd5, 0);
        checkOutput("x0_never_written", x0_we_count, x0_before);

        @(negedge clk);
        wb_valid  = 1'b1;
        wb_rd     = 5'd3;
        wb_data   = 32'h33;
        req_valid = 1'b1;
        req_rs1   = 5'd3;
        req_rs2   = 5'd0;
        #1;
        checkOutput("prio_wb_ready", wb_ready, 1);
        checkOutput("prio_req_ready", req_ready, 0);
        checkOutput("prio_rf_we", rf_we, 1);
        @(posedge clk);
        ref_regs[3] = 32'h33;
        #1;
        wb_valid = 1'b0;
        applyRead(5'd3, 5'd0, 0);

        applyRead(5'd3, 5'd5, 10);

        for (int i = 1; i < 32; i++) applyWrite(AW'(i), DW'(i + 1));
        for (int i = 1; i < 32; i++) applyRead(AW'(i), AW'(32 - i), 0);

        applyResetInRd2();

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(1, 0) == 1)
                applyWrite(AW'($urandom_range(31, 0)), $urandom);
            else
                applyRead(AW'($urandom_range(31, 0)), AW'($urandom_range(31, 0)), $urandom_range(3, 0));
        end
    endtask

    initial begin
        rst        = 1'b0;
        seed_mem   = 1'b1;
        wb_valid   = 1'b1;
        wb_rd      = 5'd7;
        wb_data    = 32'hCAFEF00D;
        req_valid  = 1'b1;
        req_rs1    = 5'd1;
        req_rs2    = 5'd2;
        opnd_ready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            seed_val[i] = $urandom;
            ref_regs[i] = seed_val[i];
        end
        seed_val[0] = 32'hBAD00000;

        @(posedge clk);
        @(negedge clk);
        seed_mem = 1'b0;
        #1;
        checkOutput("reset_req_ready", req_ready, 0);
        checkOutput("reset_wb_ready", wb_ready, 0);
        checkOutput("reset_rf_we", rf_we, 0);
        checkOutput("reset_rf_addr", rf_addr, 0);
        checkOutput("reset_rf_wdata", rf_wdata, 0);
        checkOutput("reset_opnd_valid", opnd_valid, 0);
        checkOutput("reset_rs1", opnd_rs1_data, 0);
        checkOutput("reset_rs2", opnd_rs2_data, 0);
        wb_valid  = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        applyStimulus();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end

endmodule

// File: doc/regfile_access_sequencer.md
# regfile_access_sequencer

Serialises operand reads and writeback writes onto the single-port register file (`register_file_single_port`) of the RV32I core. It sits directly upstream of that register file, between decode/issue (rs1/rs2 requests), writeback (rd writes) and execute (operand pair out). It hides the file's one-port, one-cycle-read-latency nature behind valid/ready handshakes, and it enforces x0 semantics.

## Interface
Parameters:
- `ADDR_WIDTH`, default 5: register address width (32 registers).
- `DATA_WIDTH`, default 32: register data width.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset. Asynchronous, active-low: `rst`=0 resets the block.
- `req_valid`  in  1  operand-read request valid.
- `req_ready`  out  1  request accepted on a cycle where `req_valid` and `req_ready` are both 1.
- `req_rs1`  in  ADDR_WIDTH  first source register.
- `req_rs2`  in  ADDR_WIDTH  second source register.
- `wb_valid`  in  1  writeback valid.
- `wb_ready`  out  1  writeback accepted; the write occurs on that edge.
- `wb_rd`  in  ADDR_WIDTH  destination register.
- `wb_data`  in  DATA_WIDTH  writeback data.
- `opnd_valid`  out  1  operand pair valid.
- `opnd_ready`  in  1  consumer accepts the operand pair.
- `opnd_rs1_data`  out  DATA_WIDTH  rs1 value.
- `opnd_rs2_data`  out  DATA_WIDTH  rs2 value.
- `rf_we`  out  1  register-file write enable (to `i_we`).
- `rf_addr`  out  ADDR_WIDTH  register-file address (to `i_addr`).
- `rf_wdata`  out  DATA_WIDTH  register-file write data (to `i_data`).
- `rf_rdata`  in  DATA_WIDTH  register-file read data (from `o_data`). It is valid one cycle after the address is presented.

## Operation
- FSM states: IDLE, RD1, RD2, CAP2, OUT.
- **IDLE**
  - `wb_valid`=1: `wb_ready`=1, `req_ready`=0. `rf_we`=1 unless `wb_rd`==0. `rf_addr`=`wb_rd`, `rf_wdata`=`wb_data`. Stay in IDLE.
  - `wb_valid`=0: `req_ready`=1. On handshake, latch rs1/rs2 and go to RD1.
  - Writeback has strict priority over read requests, so a read issued after a write always sees the written value.
- **RD1:** `rf_addr`=rs1; go to RD2.
- **RD2:** `rf_addr`=rs2; capture `rf_rdata` into the rs1 register (0 if rs1==0); go to CAP2.
- **CAP2:** capture `rf_rdata` into the rs2 register (0 if rs2==0); go to OUT.
- **OUT:** `opnd_valid`=1 and data held stable. On `opnd_ready`, go to IDLE.
- `rf_we`=0 in every state except a write-handshake cycle in IDLE. `wb_ready` and `req_ready` are 0 outside IDLE.
- The file is always read for x0 (fixed latency); the sequencer forces the result to 0.
- Writes to x0 are acknowledged but never drive `rf_we`.

## Timing
- Request handshake at edge E0 gives `opnd_valid`=1 after E3 (3-cycle latency).
- Minimum request-to-request spacing is 4 cycles (E0, then IDLE again after E4 when `opnd_ready` is held at 1).
- Writeback costs 1 cycle per write in IDLE; back-to-back writes are allowed and starve reads indefinitely.
- `wb_ready`, `req_ready` and the `rf_*` outputs are combinational from state and inputs. `opnd_*` outputs are registered.
- Reset values (`rst`=0, asynchronous):
  - state IDLE; `opnd_valid`=0; `opnd_rs1_data`=`opnd_rs2_data`=0.
  - `rf_we`=0, `rf_addr`=0, `rf_wdata`=0.
  - `req_ready`=`wb_ready`=0. Both ready outputs are gated by `rst`.
- Reset mid-operation: the in-flight request is discarded and no operand pair is emitted. Any write on the reset-asserting edge is suppressed.
- `opnd_ready` held at 0 in OUT: stall indefinitely; writes are not accepted meanwhile.

## Structure
- Shared package `rv32i_pkg` holds:
  - `REG_ADDR_W`=5 and `XLEN`=32.
  - the FSM state enum `rf_seq_state_t`.
  - the constant `REG_X0`=0.
- No sub-module. The sequencer does not instantiate the register file; the core top-level connects the `rf_*` ports to `register_file_single_port`.

## Test plan
- Write then read: write x5=0xDEADBEEF, then request rs1=5, rs2=0. Expect `opnd_valid` 3 cycles after the request handshake, with `opnd_rs1_data`=0xDEADBEEF and `opnd_rs2_data`=0.
- x0 write: write x0=0x12345678, then read rs1=0. Expect `wb_ready`=1, `rf_we` never asserted, and `opnd_rs1_data`=0.
- Priority: assert `wb_valid` (x3=0x33) and `req_valid` (rs1=3) in the same cycle. Expect the write accepted first, then the request; `opnd_rs1_data`=0x33.
- Backpressure: hold `opnd_ready`=0 for 10 cycles in OUT. Expect data stable, `req_ready`=0 and `wb_ready`=0 throughout; accepted when `opnd_ready`=1.
- Fill and sweep: write x1..x31 with i+1, then read pairs (i, 32-i). Every operand equals its index+1.
- Reset in RD2: drop `rst` for 1 cycle. Expect `opnd_valid` never asserted for that request, state IDLE, and a new request returning correct data.
